multi_sel_seq: RTL and testbench

//  Parametrised constant-multiple sequencer. Accepts one unsigned sample per valid/ready handshake.

---
 rtl/multi_sel_seq.sv | 111 +++++++++++
 tb/tb_multi_sel_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multi_sel_seq.sv
// multi_sel_seq: constant-multiple sequencer.
// Each accepted sample d produces STEPS registered products d*K0 .. d*K(STEPS-1)
// in consecutive cycles, with constants packed 4 bits each in KVEC.
// Optional feature macro: MULT_SEQ_SAT_EN. When it is defined, products that
// overflow OW bits are clamped to all-ones and sat_flag is raised. When it is
// undefined, products wrap to their low OW bits and sat_flag stays 0.
//
// Handshake: a sample is taken on a rising edge where in_valid & in_ready.
// in_ready is combinational. It is high in IDLE and on the last step of RUN,
// so back-to-back samples run with no idle bubble. in_valid and in_data are
// ignored whenever in_ready is low.
module multi_sel_seq #(
  parameter int                 DW    = 8,
  parameter int                 OW    = 11,
  parameter int                 STEPS = 4,
  parameter logic [4*STEPS-1:0] KVEC  = 16'h8731
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [DW-1:0]                         in_data,
  output logic                                  in_ready,
  output logic                                  input_grant,
  output logic                                  out_valid,
  output logic [OW-1:0]                         out_data,
  output logic [((STEPS > 2) ? $clog2(STEPS) : 1)-1:0] out_step,
  output logic                                  sat_flag
);

  localparam int SW = (STEPS > 2) ? $clog2(STEPS) : 1;
  localparam int PW = DW + 4;
  localparam int EW = (OW > PW) ? OW : PW;

  // Reject step counts outside the supported range at elaboration.
  if (STEPS < 2 || STEPS > 8) begin : g_bad_steps
    $error("multi_sel_seq: STEPS must be in 2..8");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [DW-1:0] d_reg;
  logic [SW-1:0] step;
  logic [SW-1:0] step_nx;
  logic          last_step;
  logic          hs;

  // Constant for a given step index.
  function automatic logic [3:0] k_at(input logic [SW-1:0] i);
    return KVEC[4*i +: 4];
  endfunction

  // Full-width product of a sample and a 4-bit constant.
  function automatic logic [PW-1:0] mul(input logic [DW-1:0] d, input logic [3:0] k);
    return PW'(d) * PW'(k);
  endfunction

  // Reduce a product to OW bits. The MSB of the result is the clamp flag.
  function automatic logic [OW:0] reduce(input logic [PW-1:0] p);
    logic [EW-1:0] pe;
    pe = EW'(p);
`ifdef MULT_SEQ_SAT_EN
    if (pe > EW'({OW{1'b1}})) return {1'b1, {OW{1'b1}}};
`endif
    return {1'b0, pe[OW-1:0]};
  endfunction

  // Ready and handshake decode.
  always_comb begin
    last_step = (step == SW'(STEPS - 1));
    step_nx   = step + SW'(1);
    in_ready  = (state == IDLE) || last_step;
    hs        = in_valid && in_ready;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      d_reg       <= '0;
      step        <= '0;
      input_grant <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_step    <= '0;
      sat_flag    <= 1'b0;
    end else begin
      input_grant <= 1'b0;
      if (hs) begin
        state                <= RUN;
        d_reg                <= in_data;
        step                 <= '0;
        out_step             <= '0;
        out_valid            <= 1'b1;
        input_grant          <= 1'b1;
        {sat_flag, out_data} <= reduce(mul(in_data, k_at('0)));
      end else if (state == RUN) begin
        if (!last_step) begin
          step                 <= step_nx;
          out_step             <= step_nx;
          {sat_flag, out_data} <= reduce(mul(d_reg, k_at(step_nx)));
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          sat_flag  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_sel_seq.sv
// Directed testbench for multi_sel_seq.
// A second instance with KVEC=16'h8F31 shares all inputs, so it also sees the
// overflowing product 255*15 = 3825. Its expectation depends on MULT_SEQ_SAT_EN.
module tb_multi_sel_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready,  in_ready_k;
  logic        input_grant, input_grant_k;
  logic        out_valid, out_valid_k;
  logic [10:0] out_data,  out_data_k;
  logic [1:0]  out_step,  out_step_k;
  logic        sat_flag,  sat_flag_k;

  int tests;
  int fails;

  multi_sel_seq u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .input_grant(input_grant), .out_valid(out_valid),
    .out_data(out_data), .out_step(out_step), .sat_flag(sat_flag)
  );

  multi_sel_seq #(.KVEC(16'h8F31)) u_dut_k (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_k), .input_grant(input_grant_k), .out_valid(out_valid_k),
    .out_data(out_data_k), .out_step(out_step_k), .sat_flag(sat_flag_k)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare the main outputs of the default instance
  task automatic chk_out(input string tag, input logic v, input logic [10:0] d,
                         input logic [1:0] s, input logic g, input logic r);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".step"},  32'(out_step),  32'(s));
    chk({tag, ".grant"}, 32'(input_grant), 32'(g));
    chk({tag, ".ready"}, 32'(in_ready),  32'(r));
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    #2;
    chk_out("rst", 1'b0, 11'd0, 2'd0, 1'b0, 1'b1);
    chk("rst.sat", 32'(sat_flag), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // 1: single sample d=10
    in_valid = 1'b1; in_data = 8'd10;
    tick();
    in_valid = 1'b0; in_data = 8'd0;
    chk_out("t1.s0", 1'b1, 11'd10, 2'd0, 1'b1, 1'b0);
    tick(); chk_out("t1.s1", 1'b1, 11'd30, 2'd1, 1'b0, 1'b0);
    tick(); chk_out("t1.s2", 1'b1, 11'd70, 2'd2, 1'b0, 1'b0);
    tick(); chk_out("t1.s3", 1'b1, 11'd80, 2'd3, 1'b0, 1'b1);
    tick(); chk_out("t1.idle", 1'b0, 11'd80, 2'd3, 1'b0, 1'b1);

    // 2: back-to-back d=10 then d=20, in_valid held high
    in_valid = 1'b1; in_data = 8'd10;
    tick(); chk_out("t2.a0", 1'b1, 11'd10, 2'd0, 1'b1, 1'b0);
    in_data = 8'd20;
    tick(); chk_out("t2.a1", 1'b1, 11'd30, 2'd1, 1'b0, 1'b0);
    tick(); chk_out("t2.a2", 1'b1, 11'd70, 2'd2, 1'b0, 1'b0);
    tick(); chk_out("t2.a3", 1'b1, 11'd80, 2'd3, 1'b0, 1'b1);
    tick(); chk_out("t2.b0", 1'b1, 11'd20, 2'd0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick(); chk_out("t2.b1", 1'b1, 11'd60, 2'd1, 1'b0, 1'b0);
    tick(); chk_out("t2.b2", 1'b1, 11'd140, 2'd2, 1'b0, 1'b0);
    tick(); chk_out("t2.b3", 1'b1, 11'd160, 2'd3, 1'b0, 1'b1);
    tick(); chk_out("t2.idle", 1'b0, 11'd160, 2'd3, 1'b0, 1'b1);

    // 3 and 4: d=255 on both instances
    in_valid = 1'b1; in_data = 8'd255;
    tick();
    in_valid = 1'b0;
    chk_out("t3.s0", 1'b1, 11'd255, 2'd0, 1'b1, 1'b0);
    chk("t3.sat0", 32'(sat_flag), 32'd0);
    chk("t4.s0", 32'(out_data_k), 32'd255);
    tick();
    chk_out("t3.s1", 1'b1, 11'd765, 2'd1, 1'b0, 1'b0);
    chk("t3.sat1", 32'(sat_flag), 32'd0);
    chk("t4.s1", 32'(out_data_k), 32'd765);
    tick();
    chk_out("t3.s2", 1'b1, 11'd1785, 2'd2, 1'b0, 1'b0);
    chk("t3.sat2", 32'(sat_flag), 32'd0);
    chk("t4.step2", 32'(out_step_k), 32'd2);
`ifdef MULT_SEQ_SAT_EN
    chk("t4.s2", 32'(out_data_k), 32'd2047);
    chk("t4.sat2", 32'(sat_flag_k), 32'd1);
`else
    chk("t4.s2", 32'(out_data_k), 32'd1777);
    chk("t4.sat2", 32'(sat_flag_k), 32'd0);
`endif
    tick();
    chk_out("t3.s3", 1'b1, 11'd2040, 2'd3, 1'b0, 1'b1);
    chk("t3.sat3", 32'(sat_flag), 32'd0);
    chk("t4.s3", 32'(out_data_k), 32'd2040);
    chk("t4.sat3", 32'(sat_flag_k), 32'd0);
    tick();
    chk("t3.idle", 32'(out_valid), 32'd0);

    // 5: asynchronous reset at step 2
    in_valid = 1'b1; in_data = 8'd10;
    tick();
    in_valid = 1'b0;
    tick();
    tick(); chk_out("t5.pre", 1'b1, 11'd70, 2'd2, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk_out("t5.rst", 1'b0, 11'd0, 2'd0, 1'b0, 1'b1);
    chk("t5.sat", 32'(sat_flag), 32'd0);
    #1 rst = 1'b1;
    tick(); chk_out("t5.rel", 1'b0, 11'd0, 2'd0, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'd7;
    tick();
    in_valid = 1'b0;
    chk_out("t5.s0", 1'b1, 11'd7, 2'd0, 1'b1, 1'b0);
    tick(); chk_out("t5.s1", 1'b1, 11'd21, 2'd1, 1'b0, 1'b0);
    tick(); chk_out("t5.s2", 1'b1, 11'd49, 2'd2, 1'b0, 1'b0);
    tick(); chk_out("t5.s3", 1'b1, 11'd56, 2'd3, 1'b0, 1'b1);
    tick();

    // 6: in_data toggled while not ready must not be captured
    in_valid = 1'b1; in_data = 8'd5;
    tick(); chk_out("t6.s0", 1'b1, 11'd5, 2'd0, 1'b1, 1'b0);
    in_data = 8'd99;
    tick(); chk_out("t6.s1", 1'b1, 11'd15, 2'd1, 1'b0, 1'b0);
    in_data = 8'd123;
    tick(); chk_out("t6.s2", 1'b1, 11'd35, 2'd2, 1'b0, 1'b0);
    in_data = 8'd77;
    tick(); chk_out("t6.s3", 1'b1, 11'd40, 2'd3, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick(); chk_out("t6.idle", 1'b0, 11'd40, 2'd3, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
